// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the multiplexed seven-segment display scanner:
//   - scan FSM state encoding (BLANK, SHOW, COMMIT)
//   - SEG_OFF: all-segments/all-anodes-off pattern (active-low)
//   - simulation timing constants used when SIM = 1
//   - hex_seg(): hex nibble to active-low segment pattern g..a
// -----------------------------------------------------------------------------
package sseg_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SHOW   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    // Short slots so a whole frame fits in a few dozen cycles in simulation.
    localparam int SIM_DIV   = 8;
    localparam int SIM_BLANK = 2;

    // Active-low segments, bit order g..a; a lit segment is a 0.
    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// -----------------------------------------------------------------------------
// hex_to_sseg
// Combinational decoder from a hex nibble plus decimal point to active-low
// cathode drive.
//   nibble  in  4  hex digit value
//   dp      in  1  decimal point on
//   seg     out 8  cathodes, active-low; [6:0] = g..a, [7] = DP
// -----------------------------------------------------------------------------
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, hex_seg(nibble)};

endmodule

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
// Scan controller for an 8-digit multiplexed seven-segment display. Each digit
// slot starts with an all-anodes-off gap (anti-ghosting) followed by the lit
// part. Digit writes land in a shadow bank and are copied to the displayed
// bank in a single COMMIT cycle at the end of every frame, so updates never tear.
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   wr_valid    in   1  write request
//   wr_ready    out  1  write accepted when wr_valid & wr_ready at rising clk
//   wr_addr     in   3  digit index (0 = rightmost, anode bit 0)
//   wr_data     in   5  [3:0] hex nibble, [4] decimal point on
//   digit_en    in   8  per-digit enable; disabled digits stay dark
//   SSEG_CA     out  8  cathodes, active-low ([7] = DP)
//   SSEG_AN     out  8  anodes, active-low, one-hot-low while lit
//   scan_idx    out  3  digit index of the current slot
//   frame_done  out  1  one-cycle pulse in the COMMIT cycle
// -----------------------------------------------------------------------------
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter bit SIM       = 1'b0,
    parameter int DIV       = 12500,
    parameter int BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [7:0] SSEG_CA,
    output logic [7:0] SSEG_AN,
    output logic [2:0] scan_idx,
    output logic       frame_done
);

    localparam int D     = SIM ? SIM_DIV : DIV;
    localparam int B     = SIM ? SIM_BLANK : BLANK_CYC;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(B - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(D - B - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       shadow_q [NUM_DIGITS];
    logic [4:0]       active_q [NUM_DIGITS];
    logic [7:0]       seg_dec;
    logic [7:0]       an_d, ca_d;
    logic             wr_accept;

    assign wr_ready   = (state_q != COMMIT);
    assign frame_done = (state_q == COMMIT);
    assign scan_idx   = idx_q;
    assign wr_accept  = wr_valid & wr_ready;

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) state_d = SHOW;
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    if (idx_q == 3'd7) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = BLANK;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = BLANK;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = BLANK;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, slot counter and digit index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Slot counter restarts on every state change.
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Shadow and active digit banks.
    // NOTE: these small flop banks are reset on purpose so the first frame
    // after reset shows defined zeros and no partial write survives a reset;
    // a storage array that needs no defined start value would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_accept) shadow_q[wr_addr] <= wr_data;
            if (state_q == COMMIT) begin
                for (int i = 0; i < NUM_DIGITS; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

    hex_to_sseg u_dec (
        .nibble (active_q[idx_q][3:0]),
        .dp     (active_q[idx_q][4]),
        .seg    (seg_dec)
    );

    // Display drive for the current state; registered below so AN and CA
    // change together one cycle after the state/index that selects them.
    always_comb begin
        an_d = SEG_OFF;
        ca_d = SEG_OFF;
        if (state_q == SHOW) begin
            ca_d = seg_dec;
            if (digit_en[idx_q]) an_d = ~(8'b1 << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SSEG_AN <= SEG_OFF;
            SSEG_CA <= SEG_OFF;
        end else begin
            SSEG_AN <= an_d;
            SSEG_CA <= ca_d;
        end
    end

endmodule
